// File: rtl/hazard_forward_unit.sv
// Execute-stage forwarding and load-use stall controller for the 16-bit pipeline.
// Define HAZARD_STATS_EN to add the saturating stallCount statistics port.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ifId_rs,
    input  logic [REG_ADDR_W-1:0] ifId_rt,
    input  logic [REG_ADDR_W-1:0] idEx_rd,
    input  logic                  idEx_regWrite,
    input  logic                  idEx_memRead,
    input  logic [REG_ADDR_W-1:0] exMem_rd,
    input  logic                  exMem_regWrite,
    input  logic                  flush,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]           stallCount
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_EX  = 2'b10;

    state_e     state_q, state_d;
    logic [1:0] fwdA_q, fwdA_d;
    logic [1:0] fwdB_q, fwdB_d;
    logic       mExRs, mExRt, mMemRs, mMemRt;
    logic       luh;

    // The newer result (EX/MEM) wins over the older one (MEM/WB); 11 can never occur.
    function automatic logic [1:0] selectFor(input logic mEx, input logic mMem);
        if (mEx) begin
            return SEL_EX;
        end else if (mMem) begin
            return SEL_MEM;
        end
        return SEL_RF;
    endfunction

    assign mExRs  = idEx_regWrite  && (idEx_rd  != '0) && (idEx_rd  == ifId_rs);
    assign mExRt  = idEx_regWrite  && (idEx_rd  != '0) && (idEx_rd  == ifId_rt);
    assign mMemRs = exMem_regWrite && (exMem_rd != '0) && (exMem_rd == ifId_rs);
    assign mMemRt = exMem_regWrite && (exMem_rd != '0) && (exMem_rd == ifId_rt);
    assign luh    = idEx_memRead && (mExRs || mExRt);

    // STALL ignores hazards so a stalled instruction always advances next cycle.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            RUN: begin
                stall = luh && !flush && !reset;
                if (stall) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        fwdA_d = selectFor(mExRs, mMemRs);
        fwdB_d = selectFor(mExRt, mMemRt);
        if (flush || stall) begin
            fwdA_d = SEL_RF;
            fwdB_d = SEL_RF;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            fwdA_q  <= SEL_RF;
            fwdB_q  <= SEL_RF;
        end else begin
            state_q <= flush ? RUN : state_d;
            fwdA_q  <= fwdA_d;
            fwdB_q  <= fwdB_d;
        end
    end

    assign forwardA = fwdA_q;
    assign forwardB = fwdB_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stallCnt_q, stallCnt_d;

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stallCnt_q <= 16'd0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stallCount = stallCnt_q;
`endif

endmodule
